// File: rtl/srtc_gen2.sv
// srtc_gen2: nibble-serial S-RTC host register port, second generation.
// Define SRTC_GEN2_READBACK_EN to read the shadow word back while in WRITE mode.
module srtc_gen2 #(
  parameter int NIBBLES     = 15,
  parameter int SYNC_STAGES = 3,
  parameter int WE_PULSE    = 6,
  parameter int DEC0_IDX    = 8,
  parameter int CENT_IDX    = 11,
  parameter int CENT_BASE   = 1
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 addr_in,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic                 reg_we,
  input  logic                 reg_oe,
  input  logic [4*NIBBLES-1:0] rtc_data_in,
  output logic [4*NIBBLES-1:0] rtc_data_out,
  output logic                 rtc_we,
  output logic                 rtc_err
);

  localparam int W = 4 * NIBBLES;

  localparam bit DEC_EN =
    (DEC0_IDX >= 0) && (DEC0_IDX < NIBBLES - 1);
  localparam bit CENT_EN =
    (CENT_IDX >= 0) && (CENT_IDX < NIBBLES - 1);

  // Clamped indices keep constant slices legal when a field is disabled.
  localparam int DEC_LO  = DEC_EN ? DEC0_IDX : 0;
  localparam int DEC_HI  = DEC_EN ? DEC0_IDX + 1 : 0;
  localparam int CENT_LO = CENT_EN ? CENT_IDX : 0;
  localparam int CENT_HI = CENT_EN ? CENT_IDX + 1 : 0;

  localparam logic [3:0] DEC_P    = 4'(DEC_LO);
  localparam logic [3:0] CENT_P   = 4'(CENT_LO);
  localparam logic [3:0] CENT_T   = 4'(CENT_BASE);
  localparam logic [7:0] CENT_OFS = 8'(10 * CENT_BASE);
  localparam logic [3:0] PTR_NONE = 4'hF;
  localparam logic [3:0] PTR_LAST = 4'(NIBBLES - 1);
  localparam logic [3:0] PULSE    = 4'(WE_PULSE);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    COMMAND,
    WRITE,
    WSTROBE
  } mode_t;

  mode_t          mode;
  logic [3:0]     ptr;
  logic [3:0]     cnt;
  logic           clr_pending;
  logic [W-1:0]   snapshot;

  logic [SYNC_STAGES-1:0] oe_sync;
  logic [SYNC_STAGES-1:0] we_sync;
  logic           oe_hist;
  logic           we_hist;
  logic           oe_ev;
  logic           we_ev;

  logic [3:0]     cmd;
  logic [3:0]     units;
  logic           hi;
  logic [3:0]     ptr_inc;
  logic [W-1:0]   wr_word;
  logic           unused_hi;

  function automatic logic [7:0] host_enc(
    input logic [3:0]   idx,
    input logic [W-1:0] w
  );
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < NIBBLES; i++)
      if (idx == 4'(i)) v = {4'h0, w[4*i +: 4]};
    if (DEC_EN && idx == DEC_P)
      v = {4'h0, w[4*DEC_LO +: 4]}
        + 8'd10 * {4'h0, w[4*DEC_HI +: 4]};
    if (CENT_EN && idx == CENT_P)
      v = {4'h0, w[4*CENT_LO +: 4]}
        + 8'd10 * {4'h0, w[4*CENT_HI +: 4]}
        - CENT_OFS;
    return v;
  endfunction

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      oe_sync <= '0;
      we_sync <= '0;
      oe_hist <= 1'b0;
      we_hist <= 1'b0;
    end else begin
      oe_sync <= {oe_sync[SYNC_STAGES-2:0], reg_oe};
      we_sync <= {we_sync[SYNC_STAGES-2:0], reg_we};
      oe_hist <= oe_sync[SYNC_STAGES-1];
      we_hist <= we_sync[SYNC_STAGES-1];
    end
  end

  assign oe_ev = enable & oe_hist & ~oe_sync[SYNC_STAGES-1];
  assign we_ev = enable & ~we_hist & we_sync[SYNC_STAGES-1];

  assign cmd       = data_in[3:0];
  assign hi        = cmd >= 4'd10;
  assign units     = hi ? cmd - 4'd10 : cmd;
  assign ptr_inc   = (ptr == PTR_NONE) ? PTR_NONE : ptr + 4'd1;
  assign unused_hi = ^data_in[7:4];

  // Host digit folded into the shadow word; decimal fields span two nibbles.
  always_comb begin
    wr_word = rtc_data_out;
    for (int i = 0; i < NIBBLES; i++)
      if (ptr == 4'(i)) wr_word[4*i +: 4] = cmd;
    if (DEC_EN && ptr == DEC_P) begin
      wr_word[4*DEC_LO +: 4] = units;
      wr_word[4*DEC_HI +: 4] = {3'b000, hi};
    end
    if (CENT_EN && ptr == CENT_P) begin
      wr_word[4*CENT_LO +: 4] = units;
      wr_word[4*CENT_HI +: 4] = CENT_T + {3'b000, hi};
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      mode         <= READ;
      ptr          <= PTR_NONE;
      clr_pending  <= 1'b0;
      data_out     <= 8'h00;
      rtc_data_out <= '0;
      snapshot     <= '0;
      rtc_we       <= 1'b0;
      rtc_err      <= 1'b0;
      cnt          <= 4'd0;
    end else if (mode == WSTROBE) begin
      if (we_ev || oe_ev) rtc_err <= 1'b1;
      if (cnt <= 4'd1) begin
        rtc_we      <= 1'b0;
        cnt         <= 4'd0;
        mode        <= clr_pending ? IDLE : WRITE;
        clr_pending <= 1'b0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else if (we_ev) begin
      if (addr_in) begin
        unique case (cmd)
          4'hD: begin
            mode <= READ;
            ptr  <= PTR_NONE;
          end
          4'hE: mode <= COMMAND;
          4'hF: ;
          default: begin
            unique case (mode)
              COMMAND: begin
                if (cmd == 4'h0) begin
                  mode         <= WRITE;
                  rtc_data_out <= rtc_data_in;
                  ptr          <= 4'h0;
                end else if (cmd == 4'h4) begin
                  rtc_data_out <= '0;
                  clr_pending  <= 1'b1;
                  rtc_we       <= 1'b1;
                  cnt          <= PULSE;
                  mode         <= WSTROBE;
                end else begin
                  mode <= IDLE;
                end
              end
              WRITE: begin
                rtc_data_out <= wr_word;
                ptr          <= ptr_inc;
                rtc_we       <= 1'b1;
                cnt          <= PULSE;
                mode         <= WSTROBE;
              end
              default: ;
            endcase
          end
        endcase
      end
    end else if (oe_ev && !addr_in) begin
      unique case (mode)
        READ: begin
          if (ptr == PTR_NONE) begin
            snapshot <= rtc_data_in;
            data_out <= 8'h0F;
            ptr      <= 4'h0;
          end else begin
            data_out <= host_enc(ptr, snapshot);
            ptr      <= (ptr >= PTR_LAST) ? PTR_NONE : ptr + 4'd1;
          end
        end
        WRITE: begin
`ifdef SRTC_GEN2_READBACK_EN
          data_out <= (ptr != 4'h0)
                    ? host_enc(ptr - 4'd1, rtc_data_out)
                    : 8'h00;
`else
          data_out <= 8'h00;
`endif
        end
        default: data_out <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_srtc_gen2.sv
// tb_srtc_gen2: randomized bench for srtc_gen2 against a nibble-array model.
// Host accesses go through the synchronisers; every result is compared with the model.
module tb_srtc_gen2;

  localparam int N        = 15;
  localparam int DEC      = 8;
  localparam int CENT     = 11;
  localparam int CB       = 1;
  localparam int WE_PULSE = 6;

  localparam int M_IDLE  = 0;
  localparam int M_READ  = 1;
  localparam int M_CMD   = 2;
  localparam int M_WRITE = 3;

  typedef int word_t[N];

  logic        clkin = 1'b0;
  logic        reset;
  logic        enable;
  logic        addr_in;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        reg_we;
  logic        reg_oe;
  logic [59:0] rtc_data_in;
  logic [59:0] rtc_data_out;
  logic        rtc_we;
  logic        rtc_err;

  always #5 clkin = ~clkin;

  srtc_gen2 dut (
    .clkin        (clkin),
    .reset        (reset),
    .enable       (enable),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .data_out     (data_out),
    .reg_we       (reg_we),
    .reg_oe       (reg_oe),
    .rtc_data_in  (rtc_data_in),
    .rtc_data_out (rtc_data_out),
    .rtc_we       (rtc_we),
    .rtc_err      (rtc_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  int run = 0;
  int pulses[$];

  always @(negedge clkin) begin
    if (rtc_we === 1'b1) run++;
    else if (run != 0) begin
      pulses.push_back(run);
      run = 0;
    end
  end

  word_t      m_rtc, m_sh, m_snap;
  int         m_mode, m_ptr;
  logic       m_err;
  logic [7:0] m_dout;

  function automatic logic [59:0] pack(input word_t a);
    logic [59:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[4*i +: 4] = 4'(a[i]);
    return p;
  endfunction

  function automatic logic [7:0] enc(input int idx, input word_t a);
    if (idx == DEC) return 8'(a[DEC] + 10 * a[DEC+1]);
    if (idx == CENT) return 8'(a[CENT] + 10 * a[CENT+1] - 10 * CB);
    return 8'(a[idx]);
  endfunction

  task automatic m_reset();
    m_mode = M_READ;
    m_ptr  = 15;
    m_dout = 8'h00;
    m_err  = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_sh[i]   = 0;
      m_snap[i] = 0;
    end
  endtask

  task automatic m_ctrl(input int d, output bit strobe);
    strobe = 1'b0;
    if (d == 13) begin
      m_mode = M_READ;
      m_ptr  = 15;
    end else if (d == 14) begin
      m_mode = M_CMD;
    end else if (d == 15) begin
    end else if (m_mode == M_CMD) begin
      if (d == 0) begin
        m_mode = M_WRITE;
        m_sh   = m_rtc;
        m_ptr  = 0;
      end else if (d == 4) begin
        for (int i = 0; i < N; i++) m_sh[i] = 0;
        strobe = 1'b1;
        m_mode = M_IDLE;
      end else begin
        m_mode = M_IDLE;
      end
    end else if (m_mode == M_WRITE) begin
      if (m_ptr < N) begin
        if (m_ptr == DEC) begin
          m_sh[DEC]   = d % 10;
          m_sh[DEC+1] = d / 10;
        end else if (m_ptr == CENT) begin
          m_sh[CENT]   = d % 10;
          m_sh[CENT+1] = CB + d / 10;
        end else begin
          m_sh[m_ptr] = d;
        end
      end
      m_ptr  = (m_ptr >= 15) ? 15 : m_ptr + 1;
      strobe = 1'b1;
    end
  endtask

  task automatic m_read();
    if (m_mode == M_READ) begin
      if (m_ptr == 15) begin
        m_snap = m_rtc;
        m_dout = 8'h0F;
        m_ptr  = 0;
      end else begin
        m_dout = enc(m_ptr, m_snap);
        m_ptr  = (m_ptr == N - 1) ? 15 : m_ptr + 1;
      end
    end else if (m_mode == M_WRITE) begin
`ifdef SRTC_GEN2_READBACK_EN
      m_dout = (m_ptr >= 1 && m_ptr - 1 < N) ? enc(m_ptr - 1, m_sh) : 8'h00;
`else
      m_dout = 8'h00;
`endif
    end else begin
      m_dout = 8'h00;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic post_write(input bit s);
    check("strobe_cnt", 64'(pulses.size()), 64'(s));
    if (pulses.size() > 0)
      check("strobe_len", 64'(pulses[0]), 64'(WE_PULSE));
    pulses.delete();
    check("shadow", 64'(rtc_data_out), 64'(pack(m_sh)));
    check("rtc_err", 64'(rtc_err), 64'(m_err));
    if (s) begin
      m_rtc       = m_sh;
      rtc_data_in = pack(m_rtc);
    end
  endtask

  task automatic do_write(input logic [3:0] d, input bit en);
    bit s;
    addr_in = 1'b1;
    data_in = {4'($urandom), d};
    enable  = en;
    reg_we  = 1'b1;
    cyc(10);
    reg_we  = 1'b0;
    cyc(4);
    enable  = 1'b1;
    s = 1'b0;
    if (en) m_ctrl(int'(d), s);
    post_write(s);
  endtask

  task automatic do_read(input string tag, input bit en);
    addr_in = 1'b0;
    enable  = en;
    reg_oe  = 1'b1;
    cyc(6);
    reg_oe  = 1'b0;
    cyc(10);
    enable  = 1'b1;
    if (en) m_read();
    check(tag, 64'(data_out), 64'(m_dout));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit s;
    int t;
    int r;
    bit en;

    reset   = 1'b1;
    enable  = 1'b1;
    addr_in = 1'b0;
    data_in = 8'h00;
    reg_we  = 1'b0;
    reg_oe  = 1'b0;
    for (int i = 0; i < N; i++) m_rtc[i] = 0;
    rtc_data_in = pack(m_rtc);
    m_reset();
    cyc(3);
    check("rst_data_out", 64'(data_out), 64'h0);
    check("rst_shadow", 64'(rtc_data_out), 64'h0);
    check("rst_rtc_we", 64'(rtc_we), 64'h0);
    check("rst_rtc_err", 64'(rtc_err), 64'h0);
    reset = 1'b0;
    cyc(2);

    // read pass over a fixed time word, wrapping back to the sentinel
    rtc_data_in = 60'h0_1_1_9_1_2_5_3_4_5_6_7_8_9_0;
    for (int i = 0; i < N; i++) m_rtc[i] = int'(rtc_data_in[4*i +: 4]);
    do_write(4'hD, 1'b1);
    for (int i = 0; i < 16; i++) do_read("read_pass", 1'b1);

    // digit writes including the 0..19 field
    do_write(4'hE, 1'b1);
    do_write(4'h0, 1'b1);
    do_write(4'h3, 1'b1);
    do_write(4'h7, 1'b1);
    for (int i = 2; i < 8; i++) do_write(4'($urandom_range(0, 9)), 1'b1);
    do_write(4'hC, 1'b1);
    check("nib1_0", 64'(rtc_data_out[7:0]), 64'h73);
    check("nib9_8", 64'(rtc_data_out[39:32]), 64'h12);

    // century field and read-back through a fresh pass
    do_write(4'h4, 1'b1);
    do_write(4'h2, 1'b1);
    do_write(4'hB, 1'b1);
    check("nib12_11", 64'(rtc_data_out[51:44]), 64'h21);
    do_write(4'hD, 1'b1);
    for (int i = 0; i < 13; i++) do_read("cent_pass", 1'b1);
    check("cent_value", 64'(data_out), 64'h0B);
    for (int i = 0; i < 3; i++) do_read("cent_pass", 1'b1);

    // clear-time command
    do_write(4'hE, 1'b1);
    do_write(4'h4, 1'b1);
    check("clr_shadow", 64'(rtc_data_out), 64'h0);
    do_read("clr_read", 1'b1);
    check("clr_read_zero", 64'(data_out), 64'h0);

    // control write landing inside the strobe window
    do_write(4'hE, 1'b1);
    do_write(4'h0, 1'b1);
    addr_in = 1'b1;
    enable  = 1'b1;
    data_in = 8'h05;
    reg_we  = 1'b1;
    cyc(1);
    reg_we  = 1'b0;
    cyc(2);
    reg_we  = 1'b1;
    cyc(1);
    data_in = 8'h0D;
    cyc(12);
    reg_we  = 1'b0;
    cyc(4);
    m_ctrl(5, s);
    m_err = 1'b1;
    post_write(s);
    do_read("coll_mode", 1'b1);

    // simultaneous we and oe edges on the data register
    do_write(4'hD, 1'b1);
    do_read("sim_pre", 1'b1);
    do_read("sim_pre", 1'b1);
    addr_in = 1'b0;
    enable  = 1'b1;
    reg_oe  = 1'b1;
    cyc(6);
    reg_oe  = 1'b0;
    reg_we  = 1'b1;
    cyc(10);
    reg_we  = 1'b0;
    cyc(4);
    check("sim_dout", 64'(data_out), 64'(m_dout));
    post_write(1'b0);
    do_read("sim_post", 1'b1);

    // reset in the middle of a strobe
    do_write(4'hE, 1'b1);
    do_write(4'h0, 1'b1);
    addr_in = 1'b1;
    data_in = 8'h06;
    reg_we  = 1'b1;
    t = 0;
    while (rtc_we !== 1'b1 && t < 30) begin
      @(negedge clkin);
      t++;
    end
    check("we_start", 64'(rtc_we), 64'h1);
    @(posedge clkin);
    @(posedge clkin);
    #1 reset = 1'b1;
    #1 check("rst_we_drop", 64'(rtc_we), 64'h0);
    reg_we = 1'b0;
    @(negedge clkin);
    reset = 1'b0;
    m_reset();
    cyc(2);
    pulses.delete();
    check("rst2_shadow", 64'(rtc_data_out), 64'h0);
    check("rst2_dout", 64'(data_out), 64'h0);
    check("rst2_err", 64'(rtc_err), 64'h0);
    do_read("rst2_read", 1'b1);

    for (int it = 0; it < 200; it++) begin
      r  = $urandom_range(0, 99);
      en = ($urandom_range(0, 9) != 0);
      if (r < 35) do_read("rnd_read", en);
      else if (r < 45) do_write(4'hD, en);
      else if (r < 55) do_write(4'hE, en);
      else if (r < 62) do_write(4'h0, en);
      else if (r < 66) do_write(4'h4, en);
      else if (r < 70) do_write(4'hF, en);
      else if (r < 92) do_write(4'($urandom_range(0, 12)), en);
      else begin
        for (int i = 0; i < N; i++) m_rtc[i] = $urandom_range(0, 15);
        rtc_data_in = pack(m_rtc);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
